systolic_mm: RTL

Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B for DATA_W-bit operands. Operands stream in one k-slice per beat over a valid/ready handshake, internal skew registers stagger rows and columns into the PE grid, a control FSM flushes the pipeline, and C is returned one row per beat over a second valid/ready port. It is the parametrised, flow-controlled successor to the fixed 5×5 PE grid and is intended to sit between the operand buffers and the result writeback path.

---
 rtl/systolic_mm_pkg.sv | 20 ++
 rtl/systolic_mm_pe.sv | 62 ++++++
 rtl/systolic_mm.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_mm_pkg.sv
// Shared types and sizing helpers for the systolic_mm matrix multiplier.
package systolic_mm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH,
      OUT
   } state_t;

   function automatic int default_acc_w(input int n, input int data_w);
      return 2 * data_w + $clog2(n);
   endfunction

   // Cycles needed after the last operand beat for the far corner PE to see its last product.
   function automatic int flush_len(input int n);
      return 2 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_mm_pe.sv
// One output-stationary MAC cell: forwards a right and b down, accumulates a*b.
// Operand signedness is selected by the SYSTOLIC_MM_SIGNED_EN macro (unsigned when undefined).
module systolic_mm_pe #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc
);

   localparam int PW = 2 * DATA_W;

   logic [PW-1:0]    prod;
   logic             prod_sign;
   logic [ACC_W-1:0] prod_ext;

`ifdef SYSTOLIC_MM_SIGNED_EN
   logic signed [PW-1:0] a_sx;
   logic signed [PW-1:0] b_sx;

   // Low PW bits of the product of sign-extended operands are the exact signed product.
   assign a_sx      = {{DATA_W{a_in[DATA_W-1]}}, a_in};
   assign b_sx      = {{DATA_W{b_in[DATA_W-1]}}, b_in};
   assign prod      = a_sx * b_sx;
   assign prod_sign = prod[PW-1];
`else
   assign prod      = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
   assign prod_sign = 1'b0;
`endif

   generate
      if (ACC_W > PW) begin : g_ext
         assign prod_ext = {{(ACC_W - PW){prod_sign}}, prod};
      end else if (ACC_W == PW) begin : g_same
         assign prod_ext = prod;
      end else begin : g_trunc
         assign prod_ext = prod[ACC_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/systolic_mm.sv
// N x N output-stationary systolic multiplier C = A*B with valid/ready operand and result ports.
// Signed operation is enabled by defining SYSTOLIC_MM_SIGNED_EN (handled inside systolic_mm_pe).
module systolic_mm
   import systolic_mm_pkg::*;
#(
   parameter int N      = 5,
   parameter int DATA_W = 8,
   parameter int ACC_W  = default_acc_w(N, DATA_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DATA_W-1:0]   in_a,
   input  logic [N*DATA_W-1:0]   in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*ACC_W-1:0]    out_row,
   output logic [$clog2(N)-1:0]  out_idx,
   output logic                  busy
);

   localparam int IW   = $clog2(N);
   localparam int FLEN = flush_len(N);
   localparam int FW   = $clog2(FLEN + 1);

   state_t          state_reg, state_next;
   logic [IW-1:0]   k_reg, k_next;
   logic [IW-1:0]   r_reg, r_next;
   logic [FW-1:0]   flush_reg, flush_next;
   logic            fire;
   logic            en;
   logic            clr;

   logic [DATA_W-1:0] a_feed [N];
   logic [DATA_W-1:0] b_feed [N];
   logic [DATA_W-1:0] a_edge [N];
   logic [DATA_W-1:0] b_edge [N];
   logic [DATA_W-1:0] a_link [N][N];
   logic [DATA_W-1:0] b_link [N][N];
   logic [ACC_W-1:0]  acc    [N][N];

   assign in_ready  = (state_reg == IDLE) || (state_reg == LOAD);
   assign out_valid = (state_reg == OUT);
   assign busy      = (state_reg != IDLE);
   assign fire      = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         r_reg     <= '0;
         flush_reg <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         r_reg     <= r_next;
         flush_reg <= flush_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      r_next     = r_reg;
      flush_next = flush_reg;
      en         = 1'b0;
      clr        = 1'b0;
      case (state_reg)
         IDLE: begin
            en = fire;
            if (fire) begin
               k_next     = IW'(1);
               state_next = LOAD;
            end
         end
         LOAD: begin
            en = fire;
            if (fire) begin
               if (k_reg == IW'(N - 1)) begin
                  k_next     = '0;
                  flush_next = '0;
                  state_next = FLUSH;
               end else begin
                  k_next = k_reg + IW'(1);
               end
            end
         end
         FLUSH: begin
            en = 1'b1;
            if (flush_reg == FW'(FLEN - 1)) begin
               flush_next = '0;
               r_next     = '0;
               state_next = OUT;
            end else begin
               flush_next = flush_reg + FW'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               if (r_reg == IW'(N - 1)) begin
                  r_next     = '0;
                  clr        = 1'b1;
                  state_next = IDLE;
               end else begin
                  r_next = r_reg + IW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Edge skew: row/column gi is delayed gi enabled cycles so matching k indices meet in each PE.
   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_skew
         assign a_feed[gi] = (state_reg == FLUSH) ? '0 : in_a[gi*DATA_W +: DATA_W];
         assign b_feed[gi] = (state_reg == FLUSH) ? '0 : in_b[gi*DATA_W +: DATA_W];
         if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_feed[gi];
            assign b_edge[gi] = b_feed[gi];
         end else begin : g_dly
            logic [DATA_W-1:0] a_dly [gi];
            logic [DATA_W-1:0] b_dly [gi];
            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  for (int s = 0; s < gi; s++) begin
                     a_dly[s] <= '0;
                     b_dly[s] <= '0;
                  end
               end else if (en) begin
                  a_dly[0] <= a_feed[gi];
                  b_dly[0] <= b_feed[gi];
                  for (int s = 1; s < gi; s++) begin
                     a_dly[s] <= a_dly[s-1];
                     b_dly[s] <= b_dly[s-1];
                  end
               end
            end
            assign a_edge[gi] = a_dly[gi-1];
            assign b_edge[gi] = b_dly[gi-1];
         end
      end

      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            logic [DATA_W-1:0] a_src;
            logic [DATA_W-1:0] b_src;
            if (gj == 0) begin : g_a_edge
               assign a_src = a_edge[gi];
            end else begin : g_a_link
               assign a_src = a_link[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
               assign b_src = b_edge[gj];
            end else begin : g_b_link
               assign b_src = b_link[gi-1][gj];
            end
            systolic_mm_pe #(
               .DATA_W(DATA_W),
               .ACC_W (ACC_W)
            ) u_pe (
               .clk  (clk),
               .rst  (rst),
               .en   (en),
               .clr  (clr),
               .a_in (a_src),
               .b_in (b_src),
               .a_out(a_link[gi][gj]),
               .b_out(b_link[gi][gj]),
               .acc  (acc[gi][gj])
            );
         end
      end

      for (gj = 0; gj < N; gj++) begin : g_out
         assign out_row[gj*ACC_W +: ACC_W] = acc[r_reg][gj];
      end
   endgenerate

   assign out_idx = r_reg;

endmodule
